// File: rtl/button_debounce.sv
// Active-low pushbutton conditioner: synchroniser, stable-time debounce FSM,
// press/release pulses, debounced level and a stretched press pulse.
module button_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned DB_WIDTH        = 17,
    parameter int unsigned STRETCH_CYCLES  = 3000002,
    parameter int unsigned ST_WIDTH        = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_stretch
);

    localparam logic [DB_WIDTH-1:0] DB_MAX = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_WIDTH-1:0] ST_MAX = ST_WIDTH'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;

    state_t                 state_q, state_d;
    logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   level_d, press_event, release_event;
    logic [ST_WIDTH-1:0]    st_cnt_q;

    // Synchroniser resets to the released level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign s_in = ~sync_q[SYNC_STAGES-1];

    // State and debounce counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_event   = 1'b0;
        release_event = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_in) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_MAX) begin
                    state_d     = PRESSED;
                    press_event = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!s_in) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_in) begin
                    state_d = PRESSED;
                end else if (cnt_q == DB_MAX) begin
                    state_d       = IDLE;
                    release_event = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            btn_level     <= level_d;
            press_pulse   <= press_event;
            release_pulse <= release_event;
        end
    end

    // Stretch counter: a press reloads it, so back-to-back presses extend without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt_q      <= '0;
            press_stretch <= 1'b0;
        end else if (press_event) begin
            st_cnt_q      <= ST_MAX;
            press_stretch <= 1'b1;
        end else if (st_cnt_q != '0) begin
            st_cnt_q      <= st_cnt_q - ST_WIDTH'(1);
            press_stretch <= 1'b1;
        end else begin
            press_stretch <= 1'b0;
        end
    end

endmodule
